reorder_buffer: RTL and testbench

- Banked in-order reorder buffer; sits directly downstream of dispatch and consumes the dispatch-side `robDispatchIf`.
- Allocates one row per dispatch cycle, with one bank slot per dispatch lane.
- Marks entries done on execution writeback.
- Retires the oldest row in program order, presenting arch/phys destination info to the rename map and free list.

---
 rtl/reorder_buffer_pkg.sv | 29 ++
 rtl/reorder_buffer_bank.sv | 48 ++++
 rtl/reorder_buffer.sv | 110 +++++++++++
 tb/tb_reorder_buffer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared sizing constants and the per-slot entry layout for the reorder buffer.
package parameters;

  localparam int unsigned DISPATCH_WIDTH       = 2;
  localparam int unsigned DISPATCH_ADDR_WIDTH  = $clog2(DISPATCH_WIDTH);
  localparam int unsigned ROB_SIZE             = 16;
  localparam int unsigned ROB_ADDR_WIDTH       = $clog2(ROB_SIZE);
  localparam int unsigned WB_WIDTH             = 2;
  localparam int unsigned PHYS_REGS_ADDR_WIDTH = 6;
  localparam int unsigned ARCH_REGS_ADDR_WIDTH = 5;

  typedef logic [ROB_ADDR_WIDTH-1:0] rob_addr_t;
  typedef logic [ROB_ADDR_WIDTH:0]   rob_ptr_t;

  typedef struct packed {
    logic                            done;
    logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
    logic [ARCH_REGS_ADDR_WIDTH-1:0] arch_rd;
    logic                            is_branch;
    logic [31:0]                     pc;
    logic [31:0]                     instr;
  } rob_entry_t;

  // Pointers carry one extra wrap bit, so plain subtraction gives the occupancy.
  function automatic rob_ptr_t rob_count(input rob_ptr_t tail, input rob_ptr_t head);
    return tail - head;
  endfunction

endpackage

// File: rtl/reorder_buffer_bank.sv
// One bank (dispatch lane) of the reorder buffer: entry storage plus valid/done flags.
module rob_bank
  import parameters::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic                     wr_valid_i,
  input  rob_addr_t                wr_addr_i,
  input  rob_entry_t               wr_entry_i,
  input  logic [WB_WIDTH-1:0]      wb_en_i,
  input  rob_addr_t [WB_WIDTH-1:0] wb_addr_i,
  input  logic                     clr_en_i,
  input  rob_addr_t                clr_addr_i,
  input  rob_addr_t                rd_addr_i,
  output logic                     rd_valid_o,
  output rob_entry_t               rd_entry_o
);

  logic [ROB_SIZE-1:0] valid_q, valid_d;
  rob_entry_t          entry_q [ROB_SIZE];

  always_comb begin
    valid_d = valid_q;
    if (clr_en_i) valid_d[clr_addr_i] = 1'b0;
    if (wr_en_i)  valid_d[wr_addr_i]  = wr_valid_i;
    if (flush_i)  valid_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Payload needs no reset: valid gates every use. A dispatch write lands after
  // the done-set so a fresh entry always starts not-done.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < WB_WIDTH; k++) begin
      if (wb_en_i[k] && valid_q[wb_addr_i[k]]) entry_q[wb_addr_i[k]].done <= 1'b1;
    end
    if (wr_en_i) entry_q[wr_addr_i] <= wr_entry_i;
  end

  assign rd_valid_o = valid_q[rd_addr_i];
  assign rd_entry_o = entry_q[rd_addr_i];

endmodule

// File: rtl/reorder_buffer.sv
// Banked in-order reorder buffer: row allocation at tail, done marking on writeback,
// whole-row retirement at head.
module reorder_buffer
  import parameters::*;
(
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic [DISPATCH_WIDTH-1:0]                            dispatch_en,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]  dispatch_phys_rd,
  input  logic [DISPATCH_WIDTH-1:0][ARCH_REGS_ADDR_WIDTH-1:0]  dispatch_arch_rd,
  input  logic [DISPATCH_WIDTH-1:0]                            dispatch_is_branch_instr,
  input  logic [DISPATCH_WIDTH-1:0][31:0]                      dispatch_pc,
  input  logic [DISPATCH_WIDTH-1:0][31:0]                      dispatch_instr,
  output logic [DISPATCH_WIDTH-1:0][DISPATCH_ADDR_WIDTH-1:0]   dispatch_bank_addr,
  output logic [DISPATCH_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]        dispatch_rob_addr,
  output logic                                                 dispatch_full,
  input  logic [WB_WIDTH-1:0]                                  wb_en,
  input  logic [WB_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]              wb_rob_addr,
  input  logic [WB_WIDTH-1:0][DISPATCH_ADDR_WIDTH-1:0]         wb_bank_addr,
  input  logic                                                 flush,
  output logic [DISPATCH_WIDTH-1:0]                            commit_en,
  output logic [DISPATCH_WIDTH-1:0][ARCH_REGS_ADDR_WIDTH-1:0]  commit_arch_rd,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]  commit_phys_rd,
  output logic [DISPATCH_WIDTH-1:0][31:0]                      commit_pc,
  output logic [DISPATCH_WIDTH-1:0]                            commit_is_branch
);

  rob_ptr_t head_q, head_d, tail_q, tail_d;
  rob_ptr_t count;
  logic     dispatch_fire, commit_fire, commit_clr;

  logic [DISPATCH_WIDTH-1:0] head_valid, head_ready;
  rob_entry_t                head_entry [DISPATCH_WIDTH];

  assign count         = rob_count(tail_q, head_q);
  assign dispatch_full = (count == rob_ptr_t'(ROB_SIZE));
  assign dispatch_fire = (|dispatch_en) && !dispatch_full && !flush;
  assign commit_fire   = (count != '0) && (&head_ready);
  assign commit_clr    = commit_fire && !flush;

  always_comb begin
    head_d = head_q + rob_ptr_t'(commit_clr);
    tail_d = tail_q + rob_ptr_t'(dispatch_fire);
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  for (genvar b = 0; b < DISPATCH_WIDTH; b++) begin : g_bank
    logic [WB_WIDTH-1:0] bank_wb_en;
    rob_entry_t          wr_entry;
    logic                unused_head_instr;

    always_comb begin
      for (int k = 0; k < WB_WIDTH; k++) begin
        bank_wb_en[k] = wb_en[k] && (wb_bank_addr[k] == DISPATCH_ADDR_WIDTH'(b)) && !flush;
      end
    end

    assign wr_entry = '{
      done:      1'b0,
      phys_rd:   dispatch_phys_rd[b],
      arch_rd:   dispatch_arch_rd[b],
      is_branch: dispatch_is_branch_instr[b],
      pc:        dispatch_pc[b],
      instr:     dispatch_instr[b]
    };

    rob_bank u_bank (
      .clk_i      (clk),
      .rst_i      (rst),
      .flush_i    (flush),
      .wr_en_i    (dispatch_fire),
      .wr_valid_i (dispatch_en[b]),
      .wr_addr_i  (tail_q[ROB_ADDR_WIDTH-1:0]),
      .wr_entry_i (wr_entry),
      .wb_en_i    (bank_wb_en),
      .wb_addr_i  (wb_rob_addr),
      .clr_en_i   (commit_clr),
      .clr_addr_i (head_q[ROB_ADDR_WIDTH-1:0]),
      .rd_addr_i  (head_q[ROB_ADDR_WIDTH-1:0]),
      .rd_valid_o (head_valid[b]),
      .rd_entry_o (head_entry[b])
    );

    // Empty lanes of a partially filled row never hold up retirement.
    assign head_ready[b]         = !head_valid[b] || head_entry[b].done;
    assign unused_head_instr     = ^head_entry[b].instr;
    assign dispatch_bank_addr[b] = DISPATCH_ADDR_WIDTH'(b);
    assign dispatch_rob_addr[b]  = tail_q[ROB_ADDR_WIDTH-1:0];

    assign commit_en[b]        = commit_fire && head_valid[b];
    assign commit_arch_rd[b]   = commit_en[b] ? head_entry[b].arch_rd   : '0;
    assign commit_phys_rd[b]   = commit_en[b] ? head_entry[b].phys_rd   : '0;
    assign commit_pc[b]        = commit_en[b] ? head_entry[b].pc        : '0;
    assign commit_is_branch[b] = commit_en[b] ? head_entry[b].is_branch : 1'b0;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a row-queue reference model predicts commits.
module tb_reorder_buffer;
  import parameters::*;

  localparam int unsigned DW = DISPATCH_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0]                            dispatch_en = '0;
  logic [DW-1:0][PHYS_REGS_ADDR_WIDTH-1:0]  dispatch_phys_rd = '0;
  logic [DW-1:0][ARCH_REGS_ADDR_WIDTH-1:0]  dispatch_arch_rd = '0;
  logic [DW-1:0]                            dispatch_is_branch_instr = '0;
  logic [DW-1:0][31:0]                      dispatch_pc = '0;
  logic [DW-1:0][31:0]                      dispatch_instr = '0;
  logic [DW-1:0][DISPATCH_ADDR_WIDTH-1:0]   dispatch_bank_addr;
  logic [DW-1:0][ROB_ADDR_WIDTH-1:0]        dispatch_rob_addr;
  logic                                     dispatch_full;
  logic [WB_WIDTH-1:0]                      wb_en = '0;
  logic [WB_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]  wb_rob_addr = '0;
  logic [WB_WIDTH-1:0][DISPATCH_ADDR_WIDTH-1:0] wb_bank_addr = '0;
  logic                                     flush = 1'b0;
  logic [DW-1:0]                            commit_en;
  logic [DW-1:0][ARCH_REGS_ADDR_WIDTH-1:0]  commit_arch_rd;
  logic [DW-1:0][PHYS_REGS_ADDR_WIDTH-1:0]  commit_phys_rd;
  logic [DW-1:0][31:0]                      commit_pc;
  logic [DW-1:0]                            commit_is_branch;

  reorder_buffer dut (
    .clk                      (clk),
    .rst                      (rst),
    .dispatch_en              (dispatch_en),
    .dispatch_phys_rd         (dispatch_phys_rd),
    .dispatch_arch_rd         (dispatch_arch_rd),
    .dispatch_is_branch_instr (dispatch_is_branch_instr),
    .dispatch_pc              (dispatch_pc),
    .dispatch_instr           (dispatch_instr),
    .dispatch_bank_addr       (dispatch_bank_addr),
    .dispatch_rob_addr        (dispatch_rob_addr),
    .dispatch_full            (dispatch_full),
    .wb_en                    (wb_en),
    .wb_rob_addr              (wb_rob_addr),
    .wb_bank_addr             (wb_bank_addr),
    .flush                    (flush),
    .commit_en                (commit_en),
    .commit_arch_rd           (commit_arch_rd),
    .commit_phys_rd           (commit_phys_rd),
    .commit_pc                (commit_pc),
    .commit_is_branch         (commit_is_branch)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit   [DW-1:0]                           valid;
    bit   [DW-1:0]                           done;
    logic [DW-1:0][ARCH_REGS_ADDR_WIDTH-1:0] arch;
    logic [DW-1:0][PHYS_REGS_ADDR_WIDTH-1:0] phys;
    logic [DW-1:0][31:0]                     pc;
    logic [DW-1:0]                           br;
  } mrow_t;

  typedef struct {
    int                                      cyc;
    logic [DW-1:0]                           en;
    logic [DW-1:0][ARCH_REGS_ADDR_WIDTH-1:0] arch;
    logic [DW-1:0][PHYS_REGS_ADDR_WIDTH-1:0] phys;
    logic [DW-1:0][31:0]                     pc;
    logic [DW-1:0]                           br;
  } exp_t;

  mrow_t rows[$];
  exp_t  exp_q[$];
  int    head_idx  = 0;
  int    cur_cyc   = 0;
  int    exp_rob   = 0;
  bit    exp_full  = 1'b0;
  bit    chk_on    = 1'b0;
  int    n_cmp     = 0;
  int    n_bad     = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cur_cyc, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs each cycle against the model's predictions.
  initial begin
    exp_t e;
    bit   exp_now;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int i = 0; i < DW; i++) begin
          check("bank_addr", 64'(dispatch_bank_addr[i]), 64'(i));
          check("rob_addr", 64'(dispatch_rob_addr[i]), 64'(exp_rob));
        end
        check("full", 64'(dispatch_full), 64'(exp_full));
        exp_now = (exp_q.size() > 0) && (exp_q[0].cyc == cur_cyc);
        check("commit_present", 64'(commit_en != '0), 64'(exp_now));
        if (exp_now) begin
          e = exp_q.pop_front();
          check("commit_en", 64'(commit_en), 64'(e.en));
          for (int i = 0; i < DW; i++) begin
            if (e.en[i]) begin
              check("commit_arch_rd", 64'(commit_arch_rd[i]), 64'(e.arch[i]));
              check("commit_phys_rd", 64'(commit_phys_rd[i]), 64'(e.phys[i]));
              check("commit_pc", 64'(commit_pc[i]), 64'(e.pc[i]));
              check("commit_is_branch", 64'(commit_is_branch[i]), 64'(e.br[i]));
            end
          end
        end
      end
    end
  end

  // Predict this cycle's outputs from the model, advance the model across the edge.
  task automatic step();
    mrow_t r;
    exp_t  e;
    bit    ready, full_pre;
    int    j, bk;
    full_pre = (rows.size() == ROB_SIZE);
    exp_full = full_pre;
    exp_rob  = (head_idx + rows.size()) % ROB_SIZE;
    ready    = (rows.size() > 0);
    if (ready) begin
      for (int i = 0; i < DW; i++) if (rows[0].valid[i] && !rows[0].done[i]) ready = 1'b0;
    end
    if (ready) begin
      e.cyc = cur_cyc; e.en = rows[0].valid; e.arch = rows[0].arch;
      e.phys = rows[0].phys; e.pc = rows[0].pc; e.br = rows[0].br;
      exp_q.push_back(e);
    end
    if (flush || rst) begin
      rows.delete();
      head_idx = 0;
    end else begin
      for (int k = 0; k < WB_WIDTH; k++) begin
        if (wb_en[k]) begin
          j  = (int'(wb_rob_addr[k]) - head_idx + ROB_SIZE) % ROB_SIZE;
          bk = int'(wb_bank_addr[k]);
          if (j < rows.size()) begin
            r = rows[j];
            if (r.valid[bk]) r.done[bk] = 1'b1;
            rows[j] = r;
          end
        end
      end
      if (ready) begin
        void'(rows.pop_front());
        head_idx = (head_idx + 1) % ROB_SIZE;
      end
      if (dispatch_en != '0 && !full_pre) begin
        r.valid = dispatch_en; r.done = '0; r.arch = dispatch_arch_rd;
        r.phys = dispatch_phys_rd; r.pc = dispatch_pc; r.br = dispatch_is_branch_instr;
        rows.push_back(r);
      end
    end
    @(posedge clk);
    #1;
    cur_cyc++;
    dispatch_en = '0;
    wb_en       = '0;
    flush       = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic set_disp(input logic [DW-1:0] en, input int a0, input int p0,
                          input int a1, input int p1);
    dispatch_en         = en;
    dispatch_arch_rd[0] = 5'(a0);
    dispatch_phys_rd[0] = PHYS_REGS_ADDR_WIDTH'(p0);
    dispatch_arch_rd[1] = 5'(a1);
    dispatch_phys_rd[1] = PHYS_REGS_ADDR_WIDTH'(p1);
    for (int i = 0; i < DW; i++) begin
      dispatch_pc[i]              = $urandom;
      dispatch_instr[i]           = $urandom;
      dispatch_is_branch_instr[i] = 1'($urandom_range(1));
    end
  endtask

  task automatic set_disp_rand(input bit allow_empty);
    logic [DW-1:0] en;
    en = allow_empty ? DW'($urandom_range(3)) : DW'($urandom_range(3, 1));
    set_disp(en, $urandom_range(31), $urandom_range(63), $urandom_range(31), $urandom_range(63));
  endtask

  task automatic set_wb(input int k, input int row, input int bank);
    wb_en[k]        = 1'b1;
    wb_rob_addr[k]  = ROB_ADDR_WIDTH'(row);
    wb_bank_addr[k] = DISPATCH_ADDR_WIDTH'(bank);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_on = 1'b1;
    idle(2);

    // Two-lane row, writebacks one cycle apart.
    set_disp(2'b11, 5, 40, 6, 41); step();
    set_wb(0, 0, 1); step();
    set_wb(0, 0, 0); step();
    idle(2);

    // Partially filled row.
    set_disp(2'b01, 7, 42, 0, 0); step();
    set_wb(1, 1, 0); step();
    idle(2);

    // Fill from row 0, overfill attempt, retire row 0, wrap dispatch.
    flush = 1'b1; step();
    for (int i = 0; i < ROB_SIZE; i++) begin set_disp(2'b11, i, i, i + 1, i + 2); step(); end
    set_disp(2'b11, 9, 9, 9, 9); step();
    set_wb(0, 0, 0); set_wb(1, 0, 1); step();
    idle(2);
    set_disp(2'b11, 11, 12, 13, 14); step();
    idle(1);

    // Out-of-order completion: row 2 before row 1.
    flush = 1'b1; step();
    for (int i = 0; i < 3; i++) begin set_disp_rand(1'b0); dispatch_en = 2'b11; step(); end
    set_wb(0, 0, 0); set_wb(1, 0, 1); step();
    set_wb(0, 2, 0); set_wb(1, 2, 1); step();
    idle(3);
    set_wb(0, 1, 0); set_wb(1, 1, 1); step();
    idle(3);

    // Flush with rows in flight and a simultaneous dispatch.
    for (int i = 0; i < 5; i++) begin set_disp_rand(1'b0); step(); end
    set_disp_rand(1'b0); flush = 1'b1; step();
    idle(2);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) != 0) set_disp_rand(1'b1);
      for (int k = 0; k < WB_WIDTH; k++) begin
        if ($urandom_range(9) < 6) begin
          if (rows.size() > 0 && $urandom_range(9) != 0)
            set_wb(k, (head_idx + $urandom_range(rows.size() - 1)) % ROB_SIZE,
                   $urandom_range(DW - 1));
          else
            set_wb(k, $urandom_range(ROB_SIZE - 1), $urandom_range(DW - 1));
        end
      end
      if ($urandom_range(99) < 2) flush = 1'b1;
      if ($urandom_range(199) == 0) rst = 1'b1;
      step();
    end

    flush = 1'b1; step();
    idle(1);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion before 500000");
    $fatal(1, "timeout");
  end

endmodule
